// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one multi-cycle memory between the instruction-fetch
// (IF) and data (DM) ports of the CPU. It allows one transaction in flight and
// uses round-robin arbitration. A watchdog aborts any access that hangs.
//
//   state | meaning
//   IDLE  | no transaction; arbitrate and latch the winning request
//   ISSUE | drive MemRead/MemWrite until the memory reports STALL
//   WAIT  | strobes low; wait for the memory to return to FREE
//   DONE  | ack the owner for one cycle and record it as last grant
`timescale 1ns/1ps
module mem_port_arbiter #(
   parameter int TIMEOUT = 16,
   parameter int AW      = 32,
   parameter int DW      = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_if_req,
   input  logic [AW-1:0] i_if_addr,
   output logic          o_if_ack,
   output logic [DW-1:0] o_if_rdata,
   output logic          o_if_stall,
   input  logic          i_dm_req,
   input  logic          i_dm_we,
   input  logic [AW-1:0] i_dm_addr,
   input  logic [DW-1:0] i_dm_wdata,
   output logic          o_dm_ack,
   output logic [DW-1:0] o_dm_rdata,
   output logic          o_dm_stall,
   output logic          o_mem_read,
   output logic          o_mem_write,
   output logic [AW-1:0] o_mem_addr,
   output logic [DW-1:0] o_mem_wd,
   input  logic [DW-1:0] i_mem_rd,
   input  logic [2:0]    i_mem_state,
   output logic          o_timeout
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [2:0] MEM_FREE  = 3'b000;
   localparam logic [2:0] MEM_STALL = 3'b111;

   localparam logic PORT_IF = 1'b0;
   localparam logic PORT_DM = 1'b1;

   localparam int             CW       = $clog2(TIMEOUT);
   localparam logic [CW-1:0]  CNT_LOAD = CW'(TIMEOUT - 1);

   logic [1:0]    r_state;
   logic          r_owner;
   logic          r_last_grant;
   logic          r_we;
   logic [AW-1:0] r_mem_addr;
   logic [DW-1:0] r_mem_wd;
   logic [DW-1:0] r_if_rdata;
   logic [DW-1:0] r_dm_rdata;
   logic [CW-1:0] r_cnt;
   logic          r_timeout;

   logic w_any_req;
   logic w_grant_dm;
   logic w_busy;
   logic w_complete;
   logic w_expire;

   // Arbitration: a lone request wins; on a tie the port that did not win last time wins.
   assign w_any_req  = i_if_req | i_dm_req;
   assign w_grant_dm = i_dm_req & (~i_if_req | (r_last_grant == PORT_IF));

   // The watchdog counts down over ISSUE and WAIT. A completion in the same cycle
   // as the terminal count takes priority over the abort.
   assign w_busy     = (r_state == S_ISSUE) | (r_state == S_WAIT);
   assign w_complete = (r_state == S_WAIT) & (i_mem_state == MEM_FREE);
   assign w_expire   = w_busy & (r_cnt == '0) & ~w_complete;

   // Transaction sequencing, data capture and watchdog.
   // An abort also goes through DONE, so the owner gets the same one-cycle ack
   // and last_grant is updated in one place.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_owner      <= PORT_IF;
         r_last_grant <= PORT_DM;
         r_we         <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wd     <= '0;
         r_if_rdata   <= '0;
         r_dm_rdata   <= '0;
         r_cnt        <= '0;
         r_timeout    <= 1'b0;
      end else if (w_expire) begin
         r_timeout <= 1'b1;
         if (r_owner == PORT_DM) r_dm_rdata <= '0;
         else                    r_if_rdata <= '0;
         r_state <= S_DONE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_owner    <= w_grant_dm;
                  r_we       <= w_grant_dm & i_dm_we;
                  r_mem_addr <= w_grant_dm ? i_dm_addr : i_if_addr;
                  r_mem_wd   <= w_grant_dm ? i_dm_wdata : '0;
                  r_cnt      <= CNT_LOAD;
                  r_state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_cnt <= r_cnt - 1'b1;
               if (i_mem_state == MEM_STALL) r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (w_complete) begin
                  if (!r_we) begin
                     if (r_owner == PORT_DM) r_dm_rdata <= i_mem_rd;
                     else                    r_if_rdata <= i_mem_rd;
                  end
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: begin
               r_last_grant <= r_owner;
               r_state      <= S_IDLE;
            end
         endcase
      end
   end

   // The strobes drop as soon as the memory reports STALL, so the memory sees a one-cycle launch.
   always_comb begin
      o_mem_read  = (r_state == S_ISSUE) & ~r_we & (i_mem_state != MEM_STALL);
      o_mem_write = (r_state == S_ISSUE) &  r_we & (i_mem_state != MEM_STALL);
      o_if_ack    = (r_state == S_DONE) & (r_owner == PORT_IF);
      o_dm_ack    = (r_state == S_DONE) & (r_owner == PORT_DM);
      o_if_stall  = i_if_req & ~o_if_ack;
      o_dm_stall  = i_dm_req & ~o_dm_ack;
   end

   assign o_mem_addr = r_mem_addr;
   assign o_mem_wd   = r_mem_wd;
   assign o_if_rdata = r_if_rdata;
   assign o_dm_rdata = r_dm_rdata;
   assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. It uses a behavioural 1KB byte memory with a
// two-cycle STALL. Expected acks are queued by the stimulus code and checked by
// a monitor.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
   localparam int TIMEOUT   = 16;
   localparam int STALL_CYC = 2;
   localparam logic [2:0] FREE  = 3'b000;
   localparam logic [2:0] STALL = 3'b111;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
   logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
   logic        if_ack, dm_ack, if_stall, dm_stall, mem_read, mem_write, timeout;
   logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wd, mem_rd;
   logic [2:0]  mem_state;
   bit          hang = 1'b0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.TIMEOUT(TIMEOUT), .AW(32), .DW(32)) dut (
      .clk(clk), .rst(rst),
      .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ack(if_ack),
      .o_if_rdata(if_rdata), .o_if_stall(if_stall),
      .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr),
      .i_dm_wdata(dm_wdata), .o_dm_ack(dm_ack), .o_dm_rdata(dm_rdata),
      .o_dm_stall(dm_stall), .o_mem_read(mem_read), .o_mem_write(mem_write),
      .o_mem_addr(mem_addr), .o_mem_wd(mem_wd), .i_mem_rd(mem_rd),
      .i_mem_state(mem_state), .o_timeout(timeout)
   );

   // Memory model: a strobe seen while FREE starts an access. The model stays in
   // STALL for STALL_CYC cycles, or forever while hang is set. Reset reloads the
   // test pattern at 0x10..0x13.
   logic [7:0] mem [0:1023];
   logic       m_we;
   logic [9:0] m_addr;
   logic [31:0] m_wd;
   int         m_cnt;
   always @(posedge clk) begin
      if (rst) begin
         mem_state <= FREE;
         mem_rd    <= '0;
         m_cnt     <= 0;
         m_we      <= 1'b0;
         m_addr    <= '0;
         m_wd      <= '0;
         mem[16] <= 8'h44; mem[17] <= 8'h33; mem[18] <= 8'h22; mem[19] <= 8'h11;
      end else if (mem_state == FREE) begin
         if (mem_read || mem_write) begin
            mem_state <= STALL;
            m_we      <= mem_write;
            m_addr    <= mem_addr[9:0];
            m_wd      <= mem_wd;
            m_cnt     <= STALL_CYC - 1;
         end
      end else if (!hang) begin
         if (m_cnt == 0) begin
            mem_state <= FREE;
            if (m_we) begin
               mem[m_addr]         <= m_wd[7:0];
               mem[m_addr + 10'd1] <= m_wd[15:8];
               mem[m_addr + 10'd2] <= m_wd[23:16];
               mem[m_addr + 10'd3] <= m_wd[31:24];
            end else begin
               mem_rd <= {mem[m_addr + 10'd3], mem[m_addr + 10'd2], mem[m_addr + 10'd1], mem[m_addr]};
            end
         end else begin
            m_cnt <= m_cnt - 1;
         end
      end
   end

   typedef struct { bit port; bit rd; logic [31:0] data; } exp_t;
   exp_t exp_q[$];
   int n_checks = 0, n_fail = 0, rd_cycles = 0, wr_cycles = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endfunction

   function automatic void fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: bound expired", name);
   endfunction

   function automatic void push_exp(input bit port, input bit rd, input logic [31:0] data);
      exp_t e;
      e.port = port; e.rd = rd; e.data = data;
      exp_q.push_back(e);
   endfunction

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (mem_read)  rd_cycles++;
         if (mem_write) wr_cycles++;
         if (!rst && (if_ack || dm_ack)) begin
            chk("single_ack", 32'(if_ack & dm_ack), 32'd0);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_ack: if_ack=%0b dm_ack=%0b, none queued", if_ack, dm_ack);
            end else begin
               e = exp_q.pop_front();
               chk("ack_port", 32'(dm_ack), 32'(e.port));
               if (e.rd) chk("ack_rdata", e.port ? dm_rdata : if_rdata, e.data);
            end
         end
      end
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input bit port, input int budget, output int cyc);
      cyc = 0;
      forever begin
         @(posedge clk); #1;
         cyc++;
         if (port ? dm_ack : if_ack) break;
         if (cyc >= budget) begin fail_now("wait_ack"); break; end
      end
   endtask

   task automatic if_read(input logic [31:0] addr, input logic [31:0] exp, input int budget, output int cyc);
      if_addr = addr;
      if_req  = 1'b1;
      push_exp(1'b0, 1'b1, exp);
      #1 chk("if_stall", 32'(if_stall), 32'd1);
      wait_ack(1'b0, budget, cyc);
      if_req = 1'b0;
   endtask

   task automatic dm_access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] exp, output int cyc);
      dm_we = we; dm_addr = addr; dm_wdata = wd;
      dm_req = 1'b1;
      push_exp(1'b1, !we, exp);
      #1 chk("dm_stall", 32'(dm_stall), 32'd1);
      wait_ack(1'b1, 40, cyc);
      dm_req = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      if_req = 1'b0; dm_req = 1'b0;
      settle(2);
      rst = 1'b0;
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, "_if_ack"},    32'(if_ack), 32'd0);
      chk({tag, "_dm_ack"},    32'(dm_ack), 32'd0);
      chk({tag, "_mem_read"},  32'(mem_read), 32'd0);
      chk({tag, "_mem_write"}, 32'(mem_write), 32'd0);
      chk({tag, "_mem_addr"},  mem_addr, 32'd0);
      chk({tag, "_mem_wd"},    mem_wd, 32'd0);
      chk({tag, "_if_rdata"},  if_rdata, 32'd0);
      chk({tag, "_dm_rdata"},  dm_rdata, 32'd0);
      chk({tag, "_timeout"},   32'(timeout), 32'd0);
      chk({tag, "_stalls"},    {30'd0, if_stall, dm_stall}, 32'd0);
   endtask

   initial begin
      int cyc, r0, w0, n_if, n_dm;
      fork
         monitor();
         begin
            #200000;
            $display("FAIL global_timeout: simulation limit reached");
            $fatal(1, "simulation limit");
         end
      join_none

      do_reset();
      check_quiet("reset");

      // IF read only: latency is 3 + memory stall, with one cycle of mem_read.
      r0 = rd_cycles; w0 = wr_cycles;
      if_read(32'h10, 32'h11223344, 40, cyc);
      chk("t1_latency", 32'(cyc), 32'(3 + STALL_CYC));
      settle(2);
      chk("t1_read_cycles", 32'(rd_cycles - r0), 32'd1);
      chk("t1_write_cycles", 32'(wr_cycles - w0), 32'd0);
      chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);

      // DM write, then read back.
      w0 = wr_cycles;
      dm_access(1'b1, 32'h20, 32'hDEADBEEF, 32'h0, cyc);
      chk("t2_wr_latency", 32'(cyc), 32'(3 + STALL_CYC));
      settle(1);
      dm_access(1'b0, 32'h20, 32'h0, 32'hDEADBEEF, cyc);
      settle(2);
      chk("t2_write_cycles", 32'(wr_cycles - w0), 32'd1);
      chk("t2_dm_rdata", dm_rdata, 32'hDEADBEEF);

      // Both ports held from reset: grant order IF, DM, IF, DM.
      do_reset();
      if_addr = 32'h10; dm_addr = 32'h20; dm_we = 1'b0;
      push_exp(1'b0, 1'b1, 32'h11223344);
      push_exp(1'b1, 1'b1, 32'hDEADBEEF);
      push_exp(1'b0, 1'b1, 32'h11223344);
      push_exp(1'b1, 1'b1, 32'hDEADBEEF);
      if_req = 1'b1; dm_req = 1'b1;
      n_if = 0; n_dm = 0; cyc = 0;
      while ((n_if < 2 || n_dm < 2) && cyc < 80) begin
         @(posedge clk); #1;
         cyc++;
         if (if_ack) begin n_if++; if (n_if == 2) if_req = 1'b0; end
         if (dm_ack) begin n_dm++; if (n_dm == 2) dm_req = 1'b0; end
      end
      if (cyc >= 80) fail_now("t3_four_txns");
      if_req = 1'b0; dm_req = 1'b0;
      settle(3);
      chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

      // Memory stuck in STALL: watchdog aborts with rdata 0 and a sticky flag.
      chk("t4_timeout_pre", 32'(timeout), 32'd0);
      hang = 1'b1;
      if_read(32'h10, 32'h0, 60, cyc);
      chk("t4_abort_latency", 32'(cyc), 32'(TIMEOUT + 1));
      chk("t4_timeout_set", 32'(timeout), 32'd1);
      hang = 1'b0;
      settle(6);
      dm_access(1'b0, 32'h20, 32'h0, 32'hDEADBEEF, cyc);
      settle(2);
      chk("t4_timeout_sticky", 32'(timeout), 32'd1);

      // Reset during WAIT: no ack, everything cleared, next read works.
      if_addr = 32'h10;
      if_req  = 1'b1;
      cyc = 0;
      do begin @(posedge clk); #1; cyc++; end while (!mem_read && cyc < 10);
      if (!mem_read) fail_now("t5_issue");
      settle(2);
      rst = 1'b1;
      if_req = 1'b0;
      settle(1);
      check_quiet("t5_rst");
      rst = 1'b0;
      settle(3);
      if_read(32'h10, 32'h11223344, 40, cyc);
      chk("t5_latency", 32'(cyc), 32'(3 + STALL_CYC));

      settle(3);
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
